// File: rtl/seg_pkg.sv
// Shared register map, CTRL field positions, reset constants and bus helpers for ahb_seg_display.
package seg_pkg;

  localparam logic [4:0] OFF_DATA     = 5'h00;
  localparam logic [4:0] OFF_CTRL     = 5'h04;
  localparam logic [4:0] OFF_RAW      = 5'h08;
  localparam logic [4:0] OFF_DIV      = 5'h0C;
  localparam logic [4:0] OFF_BLINKDIV = 5'h10;

  localparam int unsigned CTRL_DOT_LSB   = 0;
  localparam int unsigned CTRL_EN_LSB    = 4;
  localparam int unsigned CTRL_RAW_LSB   = 8;
  localparam int unsigned CTRL_BLINK_LSB = 12;

  localparam logic [7:0]  SEG_RST      = 8'h00;
  localparam logic [3:0]  SEGCS_RST    = 4'hF;
  localparam logic [23:0] BLINKDIV_RST = 24'd4_999_999;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] size;
    logic [4:0] addr;
  } ahb_phase_t;

  localparam ahb_phase_t PHASE_IDLE = '0;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << addr;
      3'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_seg_display_if.sv
// AHB-Lite slave bus bundle for ahb_seg_display; master drives requests, slave returns data.
interface ahb_seg_display_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-7-segment glyph decoder; output is {g,f,e,d,c,b,a}, active-high.
module seg_hex_decode (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    unique case (i_nibble)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
    endcase
  end
endmodule

// File: rtl/ahb_seg_display.sv
// AHB-Lite 4-digit multiplexed 7-segment display controller.
// Define SEG_BLINK_EN to add the CTRL[15:12] blink mask and the BLINKDIV register.
module ahb_seg_display
  import seg_pkg::*;
#(
  parameter logic [15:0] DIV_RST = 16'd49999
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_seg_display_if.slave bus,
  output logic [7:0]       SEG,
  output logic [3:0]       SEGCS
);
`ifdef SEG_BLINK_EN
  localparam int unsigned CtrlW = 16;
`else
  localparam int unsigned CtrlW = 12;
`endif

  ahb_phase_t       r_ph, w_ph_next;
  logic [15:0]      r_data, r_div, r_presc;
  logic [CtrlW-1:0] r_ctrl;
  logic [31:0]      r_raw;
  logic [1:0]       r_idx;
  logic [7:0]       r_seg, w_seg_next;
  logic [3:0]       r_segcs, w_cs_next;

  logic        w_wr, w_wr_div, w_blink_hit;
  logic [4:0]  w_woff;
  logic [3:0]  w_mask, w_nibble, w_en, w_dot, w_rawsel;
  logic [6:0]  w_glyph;
  logic [31:0] w_cur, w_wr_merged;
  logic        w_unused;

  assign w_unused = ^{bus.HADDR[31:5], bus.HTRANS[0]};

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  always_comb begin
    w_ph_next = PHASE_IDLE;
    if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
      w_ph_next.valid = 1'b1;
      w_ph_next.write = bus.HWRITE;
      w_ph_next.size  = bus.HSIZE;
      w_ph_next.addr  = bus.HADDR[4:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_ph <= PHASE_IDLE;
    else        r_ph <= w_ph_next;
  end

  assign w_woff   = {r_ph.addr[4:2], 2'b00};
  assign w_wr     = r_ph.valid & r_ph.write;
  assign w_wr_div = w_wr && (w_woff == OFF_DIV);
  assign w_mask   = lane_mask(r_ph.size, r_ph.addr[1:0]);

`ifdef SEG_BLINK_EN
  logic [23:0] r_blinkdiv, r_blink_cnt;
  logic        r_phase;
  logic [3:0]  w_bmask;

  assign w_bmask     = r_ctrl[CTRL_BLINK_LSB +: 4];
  assign w_blink_hit = w_bmask[r_idx] & r_phase;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_blinkdiv  <= BLINKDIV_RST;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (w_wr && (w_woff == OFF_BLINKDIV)) r_blinkdiv <= w_wr_merged[23:0];
      if (r_blink_cnt >= r_blinkdiv) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 24'd1;
      end
    end
  end
`else
  assign w_blink_hit = 1'b0;
`endif

  // Unmapped offsets read as zero; the same view feeds the write-lane merge.
  always_comb begin
    w_cur = '0;
    case (w_woff)
      OFF_DATA:     w_cur = {16'h0, r_data};
      OFF_CTRL:     w_cur = {{(32-CtrlW){1'b0}}, r_ctrl};
      OFF_RAW:      w_cur = r_raw;
      OFF_DIV:      w_cur = {16'h0, r_div};
`ifdef SEG_BLINK_EN
      OFF_BLINKDIV: w_cur = {8'h0, r_blinkdiv};
`endif
      default:      w_cur = '0;
    endcase
  end

  assign w_wr_merged = merge_lanes(w_cur, bus.HWDATA, w_mask);
  assign bus.HRDATA  = (r_ph.valid && !r_ph.write) ? w_cur : 32'h0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_data <= '0;
      r_ctrl <= '0;
      r_raw  <= '0;
      r_div  <= DIV_RST;
    end else if (w_wr) begin
      case (w_woff)
        OFF_DATA: r_data <= w_wr_merged[15:0];
        OFF_CTRL: r_ctrl <= w_wr_merged[CtrlW-1:0];
        OFF_RAW:  r_raw  <= w_wr_merged;
        OFF_DIV:  r_div  <= w_wr_merged[15:0];
        default:  ;
      endcase
    end
  end

  // A DIV write reloads the prescaler with the new value; a wrap still advances the scan.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_presc <= DIV_RST;
      r_idx   <= 2'd0;
    end else begin
      if (r_presc == 16'd0) r_idx <= r_idx + 2'd1;
      if (w_wr_div)               r_presc <= w_wr_merged[15:0];
      else if (r_presc == 16'd0)  r_presc <= r_div;
      else                        r_presc <= r_presc - 16'd1;
    end
  end

  assign w_en     = r_ctrl[CTRL_EN_LSB +: 4];
  assign w_dot    = r_ctrl[CTRL_DOT_LSB +: 4];
  assign w_rawsel = r_ctrl[CTRL_RAW_LSB +: 4];
  assign w_nibble = r_data[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_hex (
    .i_nibble(w_nibble),
    .o_seg   (w_glyph)
  );

  always_comb begin
    w_seg_next = SEG_RST;
    w_cs_next  = SEGCS_RST;
    if (w_en[r_idx] && !w_blink_hit) begin
      w_cs_next  = ~(4'b0001 << r_idx);
      w_seg_next = w_rawsel[r_idx] ? r_raw[{r_idx, 3'b000} +: 8] : {w_dot[r_idx], w_glyph};
    end
  end

  // Registered outputs: select and segments switch together on one edge.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_seg   <= SEG_RST;
      r_segcs <= SEGCS_RST;
    end else begin
      r_seg   <= w_seg_next;
      r_segcs <= w_cs_next;
    end
  end

  assign SEG   = r_seg;
  assign SEGCS = r_segcs;

endmodule

// File: tb/tb_ahb_seg_display.sv
// Directed self-checking bench for ahb_seg_display (default build, SEG_BLINK_EN undefined).
module tb_ahb_seg_display;
  logic       HCLK;
  logic       HRESET;
  logic [7:0] SEG;
  logic [3:0] SEGCS;

  ahb_seg_display_if bus_if ();

  ahb_seg_display #(
    .DIV_RST(16'd49999)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus_if),
    .SEG   (SEG),
    .SEGCS (SEGCS)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_cs  [4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, req);
  endtask

  task automatic bus_idle();
    bus_if.HSEL   = 1'b0;
    bus_if.HTRANS = 2'b00;
    bus_if.HWRITE = 1'b0;
    bus_if.HSIZE  = 3'd2;
    bus_if.HADDR  = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    bus_if.HSEL   = 1'b1;
    bus_if.HTRANS = 2'b10;
    bus_if.HWRITE = wr;
    bus_if.HSIZE  = size;
    bus_if.HADDR  = addr;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
    @(negedge HCLK);
    addr_phase(addr, 1'b1, size);
    @(negedge HCLK);
    bus_idle();
    bus_if.HWDATA = data;
    @(negedge HCLK);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    addr_phase(addr, 1'b0, 3'd2);
    @(negedge HCLK);
    bus_idle();
    data = bus_if.HRDATA;
  endtask

  // Align to the start of the digit-0 slot, then sample one point per 3-cycle slot.
  task automatic capture_scan();
    logic       found;
    logic [3:0] prev;
    found = 1'b0;
    prev  = SEGCS;
    for (int n = 0; n < 200; n++) begin
      @(negedge HCLK);
      if (SEGCS == 4'hE && prev != 4'hE) begin
        found = 1'b1;
        break;
      end
      prev = SEGCS;
    end
    check_eq("scan_sync", {31'h0, found}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = SEG;
      cap_cs[i]  = SEGCS;
      repeat (3) @(negedge HCLK);
    end
  endtask

  logic [31:0] rd;
  logic [7:0]  exp_seg [4];
  logic [3:0]  exp_cs  [4];

  initial begin
    HRESET        = 1'b1;
    bus_if.HREADY = 1'b1;
    bus_if.HWDATA = 32'h0;
    bus_idle();
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;

    // Reset state
    check_eq("rst_seg", {24'h0, SEG}, 32'h00);
    check_eq("rst_segcs", {28'h0, SEGCS}, 32'hF);
    check_eq("hreadyout", {31'h0, bus_if.HREADYOUT}, 32'h1);
    check_eq("hresp", {31'h0, bus_if.HRESP}, 32'h0);
    bus_read(32'h0C, rd); check_eq("rst_div", rd, 32'h0000C34F);
    bus_read(32'h00, rd); check_eq("rst_data", rd, 32'h0);
    bus_read(32'h04, rd); check_eq("rst_ctrl", rd, 32'h0);
    bus_read(32'h1C, rd); check_eq("unmapped_1c", rd, 32'h0);

    // Scan "4321": DATA=0x1234, all digits enabled, DIV=2
    bus_write(32'h00, 3'd2, 32'h0000_1234);
    bus_write(32'h04, 3'd2, 32'h0000_00F0);
    // Back-to-back DIV write then DIV read
    @(negedge HCLK);
    addr_phase(32'h0C, 1'b1, 3'd2);
    @(negedge HCLK);
    bus_if.HWDATA = 32'h0000_0002;
    addr_phase(32'h0C, 1'b0, 3'd2);
    @(negedge HCLK);
    bus_idle();
    check_eq("div_b2b", bus_if.HRDATA, 32'h0000_0002);
    capture_scan();
    exp_seg = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    exp_cs  = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("hex_seg%0d", i), {24'h0, cap_seg[i]}, {24'h0, exp_seg[i]});
      check_eq($sformatf("hex_cs%0d", i), {28'h0, cap_cs[i]}, {28'h0, exp_cs[i]});
    end

    // Byte write to lane 1 of DATA
    bus_write(32'h01, 3'd0, 32'h0000_AB00);
    bus_read(32'h00, rd); check_eq("byte_wr", rd, 32'h0000_AB34);

    // CTRL keeps only its defined field bits
    bus_write(32'h04, 3'd2, 32'hFFFF_FFFF);
    bus_read(32'h04, rd); check_eq("ctrl_mask", rd, 32'h0000_0FFF);

    // Raw digit 0, dotted zero on digit 2, digits 1 and 3 disabled
    bus_write(32'h00, 3'd2, 32'h0);
    bus_write(32'h08, 3'd2, 32'h0000_00FF);
    bus_write(32'h04, 3'd2, 32'h0000_0155);
    capture_scan();
    exp_seg = '{8'hFF, 8'h00, 8'hBF, 8'h00};
    exp_cs  = '{4'hE, 4'hF, 4'hB, 4'hF};
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("raw_seg%0d", i), {24'h0, cap_seg[i]}, {24'h0, exp_seg[i]});
      check_eq($sformatf("raw_cs%0d", i), {28'h0, cap_cs[i]}, {28'h0, exp_cs[i]});
    end

    // Same with all digits enabled: digit 1 shows a plain zero
    bus_write(32'h04, 3'd2, 32'h0000_01F5);
    capture_scan();
    check_eq("en_seg1", {24'h0, cap_seg[1]}, 32'h3F);
    check_eq("en_cs1", {28'h0, cap_cs[1]}, 32'hD);
    check_eq("en_seg3", {24'h0, cap_seg[3]}, 32'h3F);

    // Reset during a DIV write data phase abandons the write
    @(negedge HCLK);
    addr_phase(32'h0C, 1'b1, 3'd2);
    @(negedge HCLK);
    bus_idle();
    bus_if.HWDATA = 32'h0000_0007;
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    bus_read(32'h0C, rd); check_eq("rst_mid_div", rd, 32'h0000C34F);
    bus_read(32'h00, rd); check_eq("rst_mid_data", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
